des_uart_ctrl: RTL and testbench

- Command sequencer between the UART byte receiver/transmitter and the DES core.
- Parses framed commands from the RX byte stream: load a 64-bit key, or encrypt/decrypt one 64-bit block.
- Drives DES start/mode, waits for completion, then streams the 8 result bytes back to the TX side with ready/valid backpressure.
- Flags protocol errors (bad opcode, no key loaded, inter-byte timeout, overrun).

---
 rtl/des_uart_ctrl.sv | 170 +++++++++++++++++
 tb/tb_des_uart_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_uart_ctrl.sv
// Command sequencer between a UART byte stream and a DES core: parses key/encrypt/decrypt
// frames, runs the core once per data frame and streams the 8 result bytes back out.
module des_uart_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [63:0] des_key,
  output logic [63:0] des_data,
  output logic        des_decrypt,
  output logic        des_start,
  input  logic        des_done,
  input  logic [63:0] des_result,
  output logic        key_loaded,
  output logic        busy,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RX    = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_TX    = 3'd4;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic          is_key_q, is_key_d;
  logic          cmd_dec_q, cmd_dec_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [55:0]   shift_q, shift_d;
  logic [63:0]   key_q, key_d;
  logic [63:0]   data_q, data_d;
  logic          dec_q, dec_d;
  logic          kl_q, kl_d;
  logic [63:0]   out_q, out_d;
  logic [2:0]    idx_q, idx_d;
  logic          err_q, err_d;
  logic [63:0]   tx_shift;

  // TX handshake: tx_valid is high for the whole TX state and tx_data depends only on
  // out_q/idx_q, so the byte is held until a cycle where tx_valid && tx_ready transfers it.
  assign tx_valid    = (state_q == ST_TX);
  assign tx_shift    = out_q << {idx_q, 3'b000};
  assign tx_data     = tx_valid ? tx_shift[63:56] : 8'h00;
  assign des_start   = (state_q == ST_START);
  assign des_key     = key_q;
  assign des_data    = data_q;
  assign des_decrypt = dec_q;
  assign key_loaded  = kl_q;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d   = state_q;
    is_key_d  = is_key_q;
    cmd_dec_d = cmd_dec_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    key_d     = key_q;
    data_d    = data_q;
    dec_d     = dec_q;
    kl_d      = kl_q;
    out_d     = out_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h01 || ((rx_data == 8'h02 || rx_data == 8'h03) && kl_q)) begin
            is_key_d  = (rx_data == 8'h01);
            cmd_dec_d = (rx_data == 8'h03);
            cnt_d     = 3'd0;
            tmo_d     = '0;
            state_d   = ST_RX;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RX: begin
        // An arriving byte always beats a timeout expiring in the same cycle.
        if (rx_valid) begin
          shift_d = {shift_q[47:0], rx_data};
          cnt_d   = cnt_q + 3'd1;
          tmo_d   = '0;
          if (cnt_q == 3'd7) begin
            if (is_key_q) begin
              key_d   = {shift_q, rx_data};
              kl_d    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              data_d  = {shift_q, rx_data};
              dec_d   = cmd_dec_q;
              state_d = ST_START;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_START: begin
        err_d   = rx_valid;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        err_d = rx_valid;
        if (des_done) begin
          out_d   = des_result;
          idx_d   = 3'd0;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        err_d = rx_valid;
        if (tx_ready) begin
          if (idx_q == 3'd7) state_d = ST_IDLE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      is_key_q  <= 1'b0;
      cmd_dec_q <= 1'b0;
      cnt_q     <= 3'd0;
      tmo_q     <= '0;
      shift_q   <= 56'd0;
      key_q     <= 64'd0;
      data_q    <= 64'd0;
      dec_q     <= 1'b0;
      kl_q      <= 1'b0;
      out_q     <= 64'd0;
      idx_q     <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_key_q  <= is_key_d;
      cmd_dec_q <= cmd_dec_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      shift_q   <= shift_d;
      key_q     <= key_d;
      data_q    <= data_d;
      dec_q     <= dec_d;
      kl_q      <= kl_d;
      out_q     <= out_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_des_uart_ctrl.sv
// Bench for des_uart_ctrl: stub DES core, byte driver, TX scoreboard, frame-level model.
module tb_des_uart_ctrl;

  localparam int TMO = 16;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [63:0] des_key, des_data;
  logic        des_decrypt, des_start;
  logic        des_done = 1'b0;
  logic [63:0] des_result = 64'd0;
  logic        key_loaded, busy, err;
  logic [2:0]  dbg_state;

  des_uart_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .des_key(des_key), .des_data(des_data), .des_decrypt(des_decrypt),
    .des_start(des_start), .des_done(des_done), .des_result(des_result),
    .key_loaded(key_loaded), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] payload;
    logic        exp_err;
    logic        exp_tx;
    logic        exp_dec;
    logic [63:0] exp_key;
    logic        exp_kl;
    logic [63:0] exp_out;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  int err_cnt = 0, start_cnt = 0, hs_total = 0, frame_hs = 0, stall_cycles = 0;
  int ready_mode = 0;
  int des_delay = 2;
  int epoch = 0;
  logic [63:0] cap_key = 64'd0, cap_data = 64'd0;
  logic        cap_dec = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for the DES core: the known test vector pair, otherwise an invertible scramble.
  function automatic logic [63:0] des_model(input logic [63:0] d, input logic [63:0] k,
                                            input logic dec);
    logic [63:0] t;
    if (!dec && k == KEY && d == PT) return CT;
    if (dec && k == KEY && d == CT) return PT;
    if (!dec) return {d[31:0], d[63:32]} ^ k;
    t = d ^ k;
    return {t[31:0], t[63:32]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [63:0] w, input int gap_max);
    for (int i = 0; i < 8; i++) begin
      send_byte(w[63-8*i -: 8]);
      if (i < 7) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic push_exp(input logic [63:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[63-8*i -: 8]);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    epoch++;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int e0, s0, h0;
    e0 = err_cnt; s0 = start_cnt; h0 = hs_total;
    if (v.exp_tx) push_exp(v.exp_out);
    send_byte(v.op);
    if (v.exp_err) begin
      check({tag, "_busy_bad_op"}, {63'd0, busy}, 64'd0);
    end else begin
      send_payload(v.payload, 2);
      if (v.exp_tx) begin
        check({tag, "_start_latency"}, {63'd0, des_start}, 64'd1);
        tick();
        check({tag, "_start_one_cycle"}, {63'd0, des_start}, 64'd0);
      end
    end
    wait_idle(300, {tag, "_idle"});
    repeat (2) tick();
    check({tag, "_err"}, 64'(err_cnt - e0), {63'd0, v.exp_err});
    check({tag, "_key"}, des_key, v.exp_key);
    check({tag, "_key_loaded"}, {63'd0, key_loaded}, {63'd0, v.exp_kl});
    check({tag, "_starts"}, 64'(start_cnt - s0), {63'd0, v.exp_tx});
    check({tag, "_handshakes"}, 64'(hs_total - h0), v.exp_tx ? 64'd8 : 64'd0);
    check({tag, "_exp_q_empty"}, 64'(exp_q.size()), 64'd0);
    if (v.exp_tx) begin
      check({tag, "_des_data"}, cap_data, v.payload);
      check({tag, "_des_decrypt"}, {63'd0, cap_dec}, {63'd0, v.exp_dec});
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        frame_hs   = 0;
      end else begin
        if (err) err_cnt++;
        if (des_start) start_cnt++;
        if (prev_stall && tx_valid) check("tx_hold", {56'd0, tx_data}, {56'd0, prev_data});
        if (tx_valid && tx_ready) begin
          hs_total++;
          frame_hs++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_extra: got byte %h expected none", tx_data);
          end else begin
            check("tx_byte", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
          end
        end
        if (tx_valid && !tx_ready && frame_hs == 2) stall_cycles++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (!tx_valid) frame_hs = 0;
      end
    end
  end

  // tx_ready driver: 0 always ready, 1 random, 2 stop after 3 bytes, 3 stall byte 3 / toggle.
  initial begin
    forever begin
      tick();
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        2: tx_ready = (frame_hs < 3);
        default: begin
          if (tx_valid && frame_hs == 2 && stall_cycles < 5) tx_ready = 1'b0;
          else tx_ready = ~tx_ready;
        end
      endcase
    end
  end

  // DES core stub.
  initial begin
    int e;
    logic [63:0] res;
    forever begin
      tick();
      if (rst_n && des_start) begin
        e = epoch;
        cap_key  = des_key;
        cap_data = des_data;
        cap_dec  = des_decrypt;
        res = des_model(des_data, des_key, des_decrypt);
        repeat (des_delay) tick();
        des_done   = 1'b1;
        des_result = res;
        tick();
        des_done   = 1'b0;
        des_result = 64'd0;
        if (e == epoch) check("tx_valid_latency", {63'd0, tx_valid}, 64'd1);
      end
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    logic [63:0] key_m, w, k2;
    logic kl_m;
    int e0, h0, sel, n;

    vecs[0] = '{8'h02, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0};
    vecs[1] = '{8'h7F, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0};
    vecs[2] = '{8'h01, KEY,   1'b0, 1'b0, 1'b0, KEY,   1'b1, 64'd0};
    vecs[3] = '{8'h02, PT,    1'b0, 1'b1, 1'b0, KEY,   1'b1, CT};
    vecs[4] = '{8'h03, CT,    1'b0, 1'b1, 1'b1, KEY,   1'b1, PT};
    vecs[5] = '{8'h00, 64'd0, 1'b1, 1'b0, 1'b0, KEY,   1'b1, 64'd0};
    vecs[6] = '{8'h02, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b0, KEY, 1'b1, 64'hECCBA8866443200E};

    // Reset values.
    repeat (3) tick();
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("rst_des_key", des_key, 64'd0);
    check("rst_des_data", des_data, 64'd0);
    check("rst_des_decrypt", {63'd0, des_decrypt}, 64'd0);
    check("rst_des_start", {63'd0, des_start}, 64'd0);
    check("rst_key_loaded", {63'd0, key_loaded}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Partial key frame followed by silence: aborted, key untouched.
    e0 = err_cnt;
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
    repeat (TMO + 2) tick();
    check("tmo_err", 64'(err_cnt - e0), 64'd1);
    check("tmo_busy", {63'd0, busy}, 64'd0);
    check("tmo_key", des_key, KEY);

    // Byte arriving exactly as the timeout would expire is accepted.
    e0 = err_cnt;
    k2 = {$urandom(), $urandom()};
    send_byte(8'h01);
    for (int i = 0; i < 8; i++) begin
      send_byte(k2[63-8*i -: 8]);
      if (i == 3) repeat (TMO - 1) tick();
    end
    repeat (2) tick();
    check("tmo_edge_err", 64'(err_cnt - e0), 64'd0);
    check("tmo_edge_key", des_key, k2);
    apply_vec(vecs[2], "reload");

    // Backpressure.
    ready_mode = 3;
    stall_cycles = 0;
    w = {$urandom(), $urandom()};
    v = '{8'h02, w, 1'b0, 1'b1, 1'b0, KEY, 1'b1, des_model(w, KEY, 1'b0)};
    apply_vec(v, "bp");
    check("bp_stall_cycles", 64'(stall_cycles), 64'd5);
    ready_mode = 0;

    // Overrun during WAIT.
    des_delay = 12;
    e0 = err_cnt;
    w = {$urandom(), $urandom()};
    push_exp(des_model(w, KEY, 1'b0));
    send_byte(8'h02);
    send_payload(w, 1);
    repeat (3) tick();
    send_byte(8'h55);
    check("ovr_busy", {63'd0, busy}, 64'd1);
    check("ovr_state_wait", {61'd0, dbg_state}, 64'd3);
    wait_idle(300, "ovr_idle");
    repeat (2) tick();
    check("ovr_err", 64'(err_cnt - e0), 64'd1);
    check("ovr_exp_q_empty", 64'(exp_q.size()), 64'd0);
    des_delay = 2;

    // Reset while the fourth result byte is pending.
    ready_mode = 2;
    w = {$urandom(), $urandom()};
    push_exp(des_model(w, KEY, 1'b1));
    send_byte(8'h03);
    send_payload(w, 1);
    n = 0;
    while (!(tx_valid && frame_hs == 3) && n < 200) begin
      tick();
      n++;
    end
    check("rtx_reached_byte4", 64'(frame_hs), 64'd3);
    rst_n = 1'b0;
    #1;
    check("rtx_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rtx_tx_data", {56'd0, tx_data}, 64'd0);
    check("rtx_busy", {63'd0, busy}, 64'd0);
    check("rtx_key_loaded", {63'd0, key_loaded}, 64'd0);
    check("rtx_des_key", des_key, 64'd0);
    check("rtx_des_data", des_data, 64'd0);
    epoch++;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    ready_mode = 0;
    tick();
    apply_vec(vecs[0], "post_rst_nokey");
    apply_vec(vecs[2], "post_rst_key");
    apply_vec(vecs[3], "post_rst_enc");

    // Reset in WAIT; the late des_done must be ignored.
    des_delay = 20;
    h0 = hs_total;
    send_byte(8'h02);
    send_payload(PT, 0);
    repeat (3) tick();
    pulse_reset();
    e0 = err_cnt;
    repeat (30) tick();
    check("late_done_busy", {63'd0, busy}, 64'd0);
    check("late_done_hs", 64'(hs_total - h0), 64'd0);
    check("late_done_err", 64'(err_cnt - e0), 64'd0);
    des_delay = 2;

    // Randomized frames against the frame-level model.
    ready_mode = 1;
    key_m = 64'd0;
    kl_m = 1'b0;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      w = {$urandom(), $urandom()};
      v.payload = w;
      v.exp_dec = (sel == 2);
      v.exp_out = 64'd0;
      v.exp_tx  = 1'b0;
      v.exp_err = 1'b0;
      case (sel)
        0: begin
          v.op = 8'h01;
          key_m = w;
          kl_m = 1'b1;
        end
        1, 2: begin
          v.op = (sel == 1) ? 8'h02 : 8'h03;
          if (kl_m) begin
            v.exp_tx  = 1'b1;
            v.exp_out = des_model(w, key_m, sel == 2);
          end else begin
            v.exp_err = 1'b1;
          end
        end
        default: begin
          v.op = 8'($urandom_range(4, 255));
          v.exp_err = 1'b1;
        end
      endcase
      v.exp_key = key_m;
      v.exp_kl  = kl_m;
      apply_vec(v, $sformatf("rnd%0d", i));
    end
    ready_mode = 0;

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
